// File: rtl/oisc_port_fifo.sv
// OISC8 move-bus port with DEPTH-entry TX (bus->peripheral) and RX (peripheral->bus) FIFOs, plus status/control registers.
// Bus reads are combinational and show-ahead; a FIFO write becomes visible one cycle later; rx_ready=!rx_full, and a push into a full TX sets ovf.
module oisc_port_fifo #(
  parameter int                 DWIDTH   = 8,
  parameter int                 SAWIDTH  = 8,
  parameter int                 DAWIDTH  = 4,
  parameter int                 DEPTH    = 8,
  parameter logic [DAWIDTH-1:0] DST_TX   = 4'd11,
  parameter logic [DAWIDTH-1:0] DST_CTRL = 4'd12,
  parameter logic [SAWIDTH-1:0] SRC_RX   = 8'd30,
  parameter logic [SAWIDTH-1:0] SRC_STAT = 8'd31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               imm,
  input  logic [DAWIDTH-1:0] instr_dst,
  input  logic [SAWIDTH-1:0] instr_src,
  input  logic [DWIDTH-1:0]  bus_din,
  output logic [DWIDTH-1:0]  bus_dout,
  output logic               bus_oe,
  output logic [DWIDTH-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [DWIDTH-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] tx_mem [DEPTH];
  logic [DWIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0]     tx_cnt, rx_cnt;
  logic              ovf, unf;

  logic [DWIDTH-1:0] wdata;
  logic              push, ctrl_wr, rd_rx, rd_st;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              flush_tx, flush_rx, flag_clr;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              ovf_set, unf_set;
  logic [5:0]        st_bits;

  // An immediate is a value, not a source address, so it never selects this port as a source.
  assign wdata    = imm ? DWIDTH'(instr_src) : bus_din;
  assign push     = (instr_dst == DST_TX);
  assign ctrl_wr  = (instr_dst == DST_CTRL);
  assign rd_rx    = !imm && (instr_src == SRC_RX);
  assign rd_st    = !imm && (instr_src == SRC_STAT);
  assign bus_oe   = rd_rx | rd_st;

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign flush_tx = ctrl_wr & wdata[0];
  assign flush_rx = ctrl_wr & wdata[1];
  assign flag_clr = rd_st | (ctrl_wr & wdata[2]);

  // Full/empty come from the registered counts, so a same-cycle pop never makes room for a push (and vice versa).
  assign tx_push  = push & !tx_full & !flush_tx;
  assign tx_pop   = !tx_empty & tx_ready & !flush_tx;
  assign rx_push  = rx_valid & !rx_full & !flush_rx;
  assign rx_pop   = rd_rx & !rx_empty & !flush_rx;
  assign ovf_set  = push & tx_full & !flush_tx;
  assign unf_set  = rd_rx & rx_empty & !flush_rx;

  assign tx_data  = tx_mem[tx_rd];
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign st_bits  = {ovf, unf, tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    bus_dout = '0;
    if (rd_rx)
      bus_dout = rx_empty ? '0 : rx_mem[rx_rd];
    else if (rd_st)
      bus_dout = {{(DWIDTH-6){1'b0}}, st_bits};
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= wdata;
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (flush_tx) begin
        tx_wr  <= '0;
        tx_rd  <= '0;
        tx_cnt <= '0;
      end else begin
        if (tx_push) tx_wr <= tx_wr + AW'(1);
        if (tx_pop)  tx_rd <= tx_rd + AW'(1);
        if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CW'(1);
        else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - CW'(1);
      end

      if (flush_rx) begin
        rx_wr  <= '0;
        rx_rd  <= '0;
        rx_cnt <= '0;
      end else begin
        if (rx_push) rx_wr <= rx_wr + AW'(1);
        if (rx_pop)  rx_rd <= rx_rd + AW'(1);
        if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
        else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - CW'(1);
      end

      // A fresh event in the clearing cycle takes priority over the clear.
      ovf <= (ovf & !flag_clr) | ovf_set;
      unf <= (unf & !flag_clr) | unf_set;
    end
  end
endmodule

// File: tb/tb_oisc_port_fifo.sv
// Directed bench for oisc_port_fifo: a queue-based model checked every cycle, plus hand-computed literal checks.
module tb_oisc_port_fifo;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       imm;
  logic [3:0] instr_dst;
  logic [7:0] instr_src;
  logic [7:0] ext_din;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic       bus_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  // The bus resolves to this port's data whenever it drives.
  assign bus_din = bus_oe ? bus_dout : ext_din;

  oisc_port_fifo dut (
    .clk(clk), .rst(rst), .imm(imm), .instr_dst(instr_dst), .instr_src(instr_src),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         ovf_m, unf_m;

  function automatic logic [7:0] m_stat();
    return {2'b00, ovf_m, unf_m, txq.size() == DEPTH, txq.size() == 0,
            rxq.size() == DEPTH, rxq.size() == 0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic i, input logic [3:0] d, input logic [7:0] s);
    imm = i;
    instr_dst = d;
    instr_src = s;
  endtask

  // Compare DUT against the model for the current inputs, advance the model, then clock.
  task automatic cyc();
    bit         rd_rx, rd_st, ctrl, ftx, frx, clr, txf0, txe0, rxf0, rxe0, ovf_ev, unf_ev;
    logic [7:0] eb, wd;
    #1;
    rd_rx = !imm && instr_src == 8'd30;
    rd_st = !imm && instr_src == 8'd31;
    eb = rd_rx ? ((rxq.size() != 0) ? rxq[0] : 8'h00) : (rd_st ? m_stat() : 8'h00);
    chk("m_tx_valid", tx_valid, txq.size() != 0);
    if (txq.size() != 0) chk("m_tx_data", tx_data, txq[0]);
    chk("m_rx_ready", rx_ready, rxq.size() != DEPTH);
    chk("m_bus_oe", bus_oe, rd_rx || rd_st);
    if (rd_rx || rd_st) chk("m_bus_dout", bus_dout, eb);

    wd = imm ? instr_src : ((rd_rx || rd_st) ? eb : ext_din);
    if (!rst) begin
      txq.delete();
      rxq.delete();
      ovf_m = 0;
      unf_m = 0;
    end else begin
      ctrl = instr_dst == 4'd12;
      ftx  = ctrl && wd[0];
      frx  = ctrl && wd[1];
      clr  = rd_st || (ctrl && wd[2]);
      txf0 = txq.size() == DEPTH;
      txe0 = txq.size() == 0;
      rxf0 = rxq.size() == DEPTH;
      rxe0 = rxq.size() == 0;
      ovf_ev = instr_dst == 4'd11 && txf0 && !ftx;
      unf_ev = rd_rx && rxe0 && !frx;
      if (ftx) txq.delete();
      else begin
        if (tx_ready && !txe0) void'(txq.pop_front());
        if (instr_dst == 4'd11 && !txf0) txq.push_back(wd);
      end
      if (frx) rxq.delete();
      else begin
        if (rd_rx && !rxe0) void'(rxq.pop_front());
        if (rx_valid && !rxf0) rxq.push_back(rx_data);
      end
      ovf_m = (ovf_m && !clr) || ovf_ev;
      unf_m = (unf_m && !clr) || unf_ev;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ext_din = 8'h00; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    drive(1'b0, 4'd0, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset state and decode
    drive(1'b0, 4'd0, 8'd31);
    #1; chk("stat_reset", bus_dout, 8'h05); chk("oe_stat", bus_oe, 1'b1);
    cyc();
    drive(1'b0, 4'd0, 8'd0);
    #1; chk("oe_none", bus_oe, 1'b0);
    cyc();

    // Immediate pushes, then drain
    for (int i = 1; i <= 3; i++) begin drive(1'b1, 4'd11, 8'(i * 8'h11)); cyc(); end
    drive(1'b0, 4'd0, 8'd0);
    #1; chk("tx_valid_after_push", tx_valid, 1'b1); chk("tx_head", tx_data, 8'h11);
    tx_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin #1; chk("tx_drain", tx_data, 8'(i * 8'h11)); cyc(); end
    tx_ready = 1'b0;
    #1; chk("tx_drained", tx_valid, 1'b0);

    // Overflow by DEPTH+1 pushes
    for (int i = 0; i <= DEPTH; i++) begin drive(1'b1, 4'd11, 8'(8'h40 + i)); cyc(); end
    drive(1'b0, 4'd0, 8'd31);
    #1; chk("stat_ovf", bus_dout, 8'h29); chk("tx_head_kept", tx_data, 8'h40);
    cyc();
    #1; chk("stat_ovf_cleared", bus_dout, 8'h09);
    cyc();
    drive(1'b1, 4'd12, 8'h01); cyc();
    drive(1'b0, 4'd0, 8'd0);
    #1; chk("tx_flushed", tx_valid, 1'b0);

    // RX reads and underflow
    rx_valid = 1'b1; rx_data = 8'hA5; cyc();
    rx_data = 8'h5A; cyc();
    rx_valid = 1'b0;
    drive(1'b0, 4'd0, 8'd30);
    #1; chk("rx_rd1", bus_dout, 8'hA5); cyc();
    #1; chk("rx_rd2", bus_dout, 8'h5A); cyc();
    #1; chk("rx_rd_empty", bus_dout, 8'h00); cyc();
    drive(1'b0, 4'd0, 8'd31);
    #1; chk("stat_unf", bus_dout, 8'h15); cyc();

    // RX full and DST_TX <- SRC_RX move
    drive(1'b0, 4'd0, 8'd0);
    rx_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin rx_data = 8'(8'h60 + i); cyc(); end
    rx_data = 8'h99;
    #1; chk("rx_full_ready", rx_ready, 1'b0);
    drive(1'b0, 4'd11, 8'd30);
    #1; chk("move_src", bus_dout, 8'h60); cyc();
    rx_valid = 1'b0;
    drive(1'b0, 4'd0, 8'd31);
    #1; chk("move_ready", rx_ready, 1'b1); chk("move_tx", tx_data, 8'h60);
    chk("stat_move", bus_dout, 8'h00); cyc();

    // Flush both with simultaneous peripheral traffic
    drive(1'b1, 4'd12, 8'h03); rx_valid = 1'b1; rx_data = 8'h77; tx_ready = 1'b1; cyc();
    rx_valid = 1'b0; tx_ready = 1'b0;
    drive(1'b0, 4'd0, 8'd31);
    #1; chk("stat_flush", bus_dout, 8'h05); cyc();

    // Reset mid-transfer
    for (int i = 0; i < 3; i++) begin drive(1'b1, 4'd11, 8'(8'hA0 + i)); cyc(); end
    drive(1'b0, 4'd0, 8'd0); rx_valid = 1'b1; rx_data = 8'h55; cyc();
    rst = 1'b0; tx_ready = 1'b1; drive(1'b1, 4'd11, 8'hA3); cyc();
    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
    drive(1'b0, 4'd0, 8'd31);
    #1; chk("stat_rst", bus_dout, 8'h05); chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rx_ready", rx_ready, 1'b1); cyc();

    // Push to full TX with same-cycle pop is still dropped
    for (int i = 0; i < DEPTH; i++) begin drive(1'b1, 4'd11, 8'(8'hB0 + i)); cyc(); end
    tx_ready = 1'b1; drive(1'b1, 4'd11, 8'hEE); cyc();
    tx_ready = 1'b0; drive(1'b0, 4'd0, 8'd31);
    #1; chk("stat_full_pop", bus_dout, 8'h21); chk("tx_after_pop", tx_data, 8'hB1); cyc();

    // Pop from empty RX with same-cycle push is refused
    rx_valid = 1'b1; rx_data = 8'h77; drive(1'b0, 4'd0, 8'd30);
    #1; chk("rx_empty_push", bus_dout, 8'h00); cyc();
    rx_valid = 1'b0;
    drive(1'b1, 4'd12, 8'h04); cyc();
    drive(1'b0, 4'd0, 8'd31);
    #1; chk("stat_ctrl_clr", bus_dout, 8'h00); cyc();
    drive(1'b0, 4'd0, 8'd30);
    #1; chk("rx_late_push", bus_dout, 8'h77); cyc();

    // Overflow during a status read: the set wins
    drive(1'b1, 4'd11, 8'hC0); cyc();
    drive(1'b0, 4'd11, 8'd31);
    #1; chk("stat_pre_clear", bus_dout, 8'h09); cyc();
    drive(1'b0, 4'd0, 8'd31);
    #1; chk("stat_set_wins", bus_dout, 8'h29); cyc();
    #1; chk("stat_final", bus_dout, 8'h09); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
